// File: rtl/dpram_pkg.sv
// Shared widths and types for the dual-port-RAM FIFO controller.
package dpram_pkg;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 2 ** AW;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [AW+3:0] lvl_t;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop byte-stream handshake bundle between producer, FIFO controller and consumer.
interface dpram_fifo_ctrl_if;
    import dpram_pkg::*;

    logic  in_valid;
    data_t in_data;
    logic  in_ready;
    logic  out_valid;
    data_t out_data;
    logic  out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/dpram_fifo_obuf.sv
// Small register queue that holds bytes returned from the RAM until the consumer takes them.
module dpram_fifo_obuf
    import dpram_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     wr,
    input  data_t                    wdata,
    input  logic                     pop,
    output logic                     valid,
    output data_t                    data,
    output logic [$clog2(ENTRIES):0] count
);

    localparam int IW = $clog2(ENTRIES);

    data_t         mem [ENTRIES];
    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW:0]   count_q;
    data_t         last_q;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);
    assign valid  = (count_q != '0);
    assign count  = count_q;
    // When empty, present the most recently popped byte rather than a stale slot.
    assign data   = valid ? mem[head] : last_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[tail] <= wdata;
                tail      <= tail + IW'(1);
            end
            if (do_pop) begin
                last_q <= mem[head];
                head   <= head + IW'(1);
            end
            case ({wr, do_pop})
                2'b10:   count_q <= count_q + (IW+1)'(1);
                2'b01:   count_q <= count_q - (IW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a 64x8 dual-port RAM: port A writes, port B reads into a small output buffer.
// Optional almost_full/almost_empty flags are built when DPRAM_FIFO_ALMOST_EN is defined.
module dpram_fifo_ctrl
    import dpram_pkg::*;
#(
    parameter int OBUF_DEPTH = 4
`ifdef DPRAM_FIFO_ALMOST_EN
   ,parameter int AFULL_TH   = 56,
    parameter int AEMPTY_TH  = 4
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    dpram_fifo_ctrl_if.slave   stream,
    output lvl_t               level,
    output logic               ram_wr_en_a,
    output addr_t              ram_addr_a,
    output data_t              ram_data_a,
    output logic               ram_wr_en_b,
    output addr_t              ram_addr_b,
    input  data_t              ram_rdata_b
`ifdef DPRAM_FIFO_ALMOST_EN
   ,output logic               almost_full,
    output logic               almost_empty
`endif
);

    addr_t                       wr_ptr;
    addr_t                       rd_ptr;
    cnt_t                        ram_count;
    logic                        inflight;
    logic                        clear;
    logic                        push;
    logic                        issue;
    logic                        obuf_valid;
    data_t                       obuf_data;
    logic [$clog2(OBUF_DEPTH):0] obuf_count;

    assign clear = !rst_n || flush;

    assign stream.in_ready = (ram_count < cnt_t'(DEPTH));
    // A push coinciding with reset or flush is dropped, so it must not touch the RAM either.
    assign push  = stream.in_valid && stream.in_ready && !clear;
    assign issue = (ram_count != '0) && ((int'(obuf_count) + int'(inflight)) < OBUF_DEPTH);

    assign ram_wr_en_a = push;
    assign ram_addr_a  = wr_ptr;
    assign ram_data_a  = stream.in_data;
    assign ram_wr_en_b = 1'b0;
    assign ram_addr_b  = rd_ptr;

    assign level = lvl_t'(ram_count) + lvl_t'(inflight) + lvl_t'(obuf_count);

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + addr_t'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + addr_t'(1);
            end
            inflight  <= issue;
            ram_count <= ram_count + cnt_t'(push) - cnt_t'(issue);
        end
    end

    // Read data arrives one cycle after issue; a clear discards it instead of capturing.
    dpram_fifo_obuf #(
        .ENTRIES (OBUF_DEPTH)
    ) u_obuf (
        .clk   (clk),
        .clear (clear),
        .wr    (inflight && !clear),
        .wdata (ram_rdata_b),
        .pop   (stream.out_ready),
        .valid (obuf_valid),
        .data  (obuf_data),
        .count (obuf_count)
    );

    assign stream.out_valid = obuf_valid;
    assign stream.out_data  = obuf_data;

`ifdef DPRAM_FIFO_ALMOST_EN
    // Flush is not a reset here, so the flags follow the cleared level one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (level >= lvl_t'(AFULL_TH));
            almost_empty <= (level <= lvl_t'(AEMPTY_TH));
        end
    end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural RAM and a byte-queue reference model.
module tb_dpram_fifo_ctrl;
    import dpram_pkg::*;

    localparam int OBUF   = 4;
    localparam int AF_TH  = 56;
    localparam int AE_TH  = 4;

    logic  clk;
    logic  rst_n;
    logic  flush;
    lvl_t  level;
    logic  ram_wr_en_a;
    addr_t ram_addr_a;
    data_t ram_data_a;
    logic  ram_wr_en_b;
    addr_t ram_addr_b;
    data_t ram_rdata_b;
`ifdef DPRAM_FIFO_ALMOST_EN
    logic  almost_full;
    logic  almost_empty;
`endif

    dpram_fifo_ctrl_if bus ();

    dpram_fifo_ctrl #(
        .OBUF_DEPTH (OBUF)
`ifdef DPRAM_FIFO_ALMOST_EN
       ,.AFULL_TH   (AF_TH),
        .AEMPTY_TH  (AE_TH)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .stream      (bus.slave),
        .level       (level),
        .ram_wr_en_a (ram_wr_en_a),
        .ram_addr_a  (ram_addr_a),
        .ram_data_a  (ram_data_a),
        .ram_wr_en_b (ram_wr_en_b),
        .ram_addr_b  (ram_addr_b),
        .ram_rdata_b (ram_rdata_b)
`ifdef DPRAM_FIFO_ALMOST_EN
       ,.almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    data_t ram [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'hEE;
    end

    always @(posedge clk) begin
        if (ram_wr_en_a) ram[ram_addr_a] <= ram_data_a;
        ram_rdata_b <= ram[ram_addr_b];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    checks   = 0;
    int    failures = 0;
    bit    armed    = 0;
    data_t exp_q[$];
    int    model_level = 0;
    int    exp_waddr   = 0;
    int    pop_cyc[$];
    int    pop_total   = 0;
    int    first_valid_cyc = -1;
    bit    exp_af = 0;
    bit    exp_ae = 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input data_t d, input logic r, input logic f);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        flush         = f;
    endtask

    // Monitor: samples mid-cycle, predicts each handshake and compares against the byte queue.
    always @(negedge clk) begin
        if (armed) begin
            int cur_level;
            cur_level = model_level;
            checkOutput("level", int'(level), model_level);
`ifdef DPRAM_FIFO_ALMOST_EN
            checkOutput("almost_full", int'(almost_full), int'(exp_af));
            checkOutput("almost_empty", int'(almost_empty), int'(exp_ae));
            if (!rst_n) begin
                exp_af = 0;
                exp_ae = 1;
            end else begin
                exp_af = (cur_level >= AF_TH);
                exp_ae = (cur_level <= AE_TH);
            end
`endif
            if (!rst_n || flush) begin
                exp_q.delete();
                model_level = 0;
                exp_waddr   = 0;
            end else begin
                checkOutput("ram_wr_en_b", int'(ram_wr_en_b), 0);
                if (bus.in_valid && bus.in_ready) begin
                    checkOutput("ram_wr_en_a", int'(ram_wr_en_a), 1);
                    checkOutput("ram_addr_a", int'(ram_addr_a), exp_waddr);
                    checkOutput("ram_data_a", int'(ram_data_a), int'(bus.in_data));
                    exp_q.push_back(bus.in_data);
                    model_level++;
                    exp_waddr = (exp_waddr + 1) % DEPTH;
                end else begin
                    checkOutput("ram_wr_en_a_idle", int'(ram_wr_en_a), 0);
                end
                if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_out: got %0d expected no output", bus.out_data);
                    end else begin
                        data_t e;
                        e = exp_q.pop_front();
                        checkOutput("out_data", int'(bus.out_data), int'(e));
                    end
                    model_level--;
                    pop_cyc.push_back(cyc);
                    pop_total++;
                end
            end
        end
    end

    initial begin
        int k;
        int push_cyc;
        int base;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        armed = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_out_data", int'(bus.out_data), 0);
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_addr_a", int'(ram_addr_a), 0);
        checkOutput("rst_addr_b", int'(ram_addr_b), 0);

        // Three back-to-back bytes: latency and consecutive delivery.
        first_valid_cyc = -1;
        pop_cyc.delete();
        applyStimulus(1, 8'h11, 1, 0);
        push_cyc = cyc;
        applyStimulus(1, 8'h22, 1, 0);
        applyStimulus(1, 8'h33, 1, 0);
        for (int i = 0; i < 20 && pop_cyc.size() < 3; i++) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("latency", first_valid_cyc - push_cyc, 3);
        checkOutput("pop_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) checkOutput("back_to_back", pop_cyc[2] - pop_cyc[0], 2);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("drain_level", int'(level), 0);
        checkOutput("empty_hold", int'(bus.out_data), 8'h33);

        // Fill with the consumer stalled: RAM plus output buffer.
        k = 0;
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1, 8'(k), 0, 0);
            if (bus.in_ready) k++;
        end
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("fill_accepted", k, DEPTH + OBUF);
        checkOutput("fill_level", int'(level), DEPTH + OBUF);
        checkOutput("fill_in_ready", int'(bus.in_ready), 0);
        for (int i = 0; i < 200 && model_level != 0; i++) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("fill_drained", int'(level), 0);

        // Continuous streaming at full rate.
        base = pop_total;
        for (int i = 0; i < 200; i++) applyStimulus(1, 8'($urandom), 1, 0);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("stream_pops", pop_total - base, 197);
        checkOutput("stream_level", int'(level), 3);
        for (int i = 0; i < 50 && model_level != 0; i++) applyStimulus(0, 8'h00, 1, 0);

        // Alternating consumer readiness.
        for (int i = 0; i < 300; i++) applyStimulus(($urandom % 4) != 0, 8'($urandom), i[0], 0);
        for (int i = 0; i < 300 && model_level != 0; i++) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("toggle_drained", int'(level), 0);

        // Reset while a RAM read is in flight.
        for (int i = 0; i < 11; i++) applyStimulus(1, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("pre_reset_level", int'(level), 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("mid_rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("mid_rst_level", int'(level), 0);
        checkOutput("mid_rst_in_ready", int'(bus.in_ready), 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("post_rst_out_valid", int'(bus.out_valid), 0);

        // Flush with data stored, then the FIFO must work from empty.
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h50 + i), 0, 0);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("flush_level", int'(level), 0);
        applyStimulus(1, 8'h77, 1, 0);
        applyStimulus(1, 8'h78, 1, 0);
        for (int i = 0; i < 20 && model_level != 0; i++) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("post_flush_level", int'(level), 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom % 3) != 0, 8'($urandom), ($urandom % 3) != 0,
                          ($urandom_range(0, 80) == 0));
        end
        for (int i = 0; i < 300 && model_level != 0; i++) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("final_level", int'(level), 0);
        checkOutput("final_queue", exp_q.size(), 0);

        @(posedge clk);
        #1;
        armed = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
